// File: rtl/qmax_finder.sv
// Greedy-action search: reads every action's Q-value for one state from the
// Q-table and reports the signed maximum together with the action achieving it.
module qmax_finder #(
  parameter int STATE_WIDTH  = 17,
  parameter int ACTION_WIDTH = 2,
  parameter int ADDR_WIDTH   = 19,
  parameter int DATA_WIDTH   = 32
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_start,
  input  logic [STATE_WIDTH-1:0]  i_state,
  output logic                    o_busy,
  output logic                    o_done,
  output logic [DATA_WIDTH-1:0]   o_qmax,
  output logic [ACTION_WIDTH-1:0] o_amax,
  output logic                    o_read_en,
  output logic [ADDR_WIDTH-1:0]   o_addr_r,
  input  logic [DATA_WIDTH-1:0]   i_q_data
);

  localparam logic [ACTION_WIDTH-1:0] LAST_ACT = '1;
  localparam logic [ACTION_WIDTH-1:0] ACT_ONE  = 1;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

  state_t                         state_q, state_d;
  logic [STATE_WIDTH-1:0]         state_reg_q, state_reg_d;
  logic                           read_en_q, read_en_d;
  logic [ADDR_WIDTH-1:0]          addr_q, addr_d;
  logic                           vld_p1_q, vld_p1_d;
  logic [ACTION_WIDTH-1:0]        act_p1_q, act_p1_d;
  logic signed [DATA_WIDTH-1:0]   run_max_q, run_max_d;
  logic [ACTION_WIDTH-1:0]        run_arg_q, run_arg_d;
  logic signed [DATA_WIDTH-1:0]   qmax_q, qmax_d;
  logic [ACTION_WIDTH-1:0]        amax_q, amax_d;
  logic [ACTION_WIDTH-1:0]        cur_act;

  assign cur_act = addr_q[ACTION_WIDTH-1:0];

  // Stage p0: sequencing and read-address generation
  always_comb begin
    state_d     = state_q;
    state_reg_d = state_reg_q;
    read_en_d   = 1'b0;
    addr_d      = addr_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (i_start) begin
          state_d     = S_READ;
          state_reg_d = i_state;
          read_en_d   = 1'b1;
          addr_d      = {i_state, {ACTION_WIDTH{1'b0}}};
        end else begin
          state_d = S_IDLE;
        end
      end
      S_READ: begin
        if (cur_act == LAST_ACT) begin
          state_d = S_DRAIN;
        end else begin
          read_en_d = 1'b1;
          addr_d    = {state_reg_q, cur_act + ACT_ONE};
        end
      end
      S_DRAIN: state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  // Stage p1: tags meet returning data; action 0 always seeds the running max
  always_comb begin
    vld_p1_d  = read_en_q;
    act_p1_d  = cur_act;
    run_max_d = run_max_q;
    run_arg_d = run_arg_q;
    if (vld_p1_q) begin
      if (act_p1_q == '0 || $signed(i_q_data) > run_max_q) begin
        run_max_d = $signed(i_q_data);
        run_arg_d = act_p1_q;
      end
    end
    qmax_d = qmax_q;
    amax_d = amax_q;
    if (state_q == S_DRAIN) begin
      qmax_d = run_max_d;
      amax_d = run_arg_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= S_IDLE;
      state_reg_q <= '0;
      read_en_q   <= 1'b0;
      addr_q      <= '0;
      vld_p1_q    <= 1'b0;
      act_p1_q    <= '0;
      run_max_q   <= '0;
      run_arg_q   <= '0;
      qmax_q      <= '0;
      amax_q      <= '0;
    end else begin
      state_q     <= state_d;
      state_reg_q <= state_reg_d;
      read_en_q   <= read_en_d;
      addr_q      <= addr_d;
      vld_p1_q    <= vld_p1_d;
      act_p1_q    <= act_p1_d;
      run_max_q   <= run_max_d;
      run_arg_q   <= run_arg_d;
      qmax_q      <= qmax_d;
      amax_q      <= amax_d;
    end
  end

  assign o_busy    = (state_q == S_READ) || (state_q == S_DRAIN);
  assign o_done    = (state_q == S_DONE);
  assign o_qmax    = qmax_q;
  assign o_amax    = amax_q;
  assign o_read_en = read_en_q;
  assign o_addr_r  = addr_q;

endmodule

// File: doc/qmax_finder.md
# qmax_finder

Greedy-action search stage that sits directly upstream of the Q-table BRAM read port. Given a state index, it issues one read per action to the Q-table, compares the returned signed Q-values, and reports the maximum Q-value and its action index. The Q-update datapath uses the results as max_a' Q(s',a') for the Bellman target, and the action-selection logic uses them as the greedy action.

## Interface
- STATE_WIDTH, 17, state index width.
- ACTION_WIDTH, 2, action index width; NUM_ACTIONS = 2**ACTION_WIDTH.
- ADDR_WIDTH, 19, Q-table address width; must equal STATE_WIDTH+ACTION_WIDTH.
- DATA_WIDTH, 32, Q-value width, signed two's complement.

- i_clk  in  1  single clock, all logic on rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_start  in  1  request a search; accepted only when o_busy=0.
- i_state  in  STATE_WIDTH  state to search; sampled with an accepted i_start.
- o_busy  out  1  search in progress.
- o_done  out  1  one-cycle pulse: o_qmax/o_amax valid.
- o_qmax  out  DATA_WIDTH  maximum Q-value of the last completed search.
- o_amax  out  ACTION_WIDTH  action achieving o_qmax.
- o_read_en  out  1  to the Q-table i_read_en.
- o_addr_r  out  ADDR_WIDTH  to the Q-table i_addr_r; address = {state, action}.
- i_q_data  in  DATA_WIDTH  from the Q-table o_data; valid the cycle after o_read_en was high.

## Operation
- FSM states:
  - IDLE: o_busy=0.
  - READ: issues NUM_ACTIONS reads.
  - DRAIN: last read returns.
  - DONE: o_done=1, o_busy=0.
- Transitions:
  - IDLE→READ on i_start.
  - READ→DRAIN after the read with action NUM_ACTIONS-1.
  - DRAIN→DONE.
  - DONE→READ if i_start, otherwise IDLE.
- An accepted i_start latches i_state into an internal register. The search uses the latched value only, so later i_state changes have no effect.
- i_start while o_busy=1 is ignored. It is not queued.
- READ: o_read_en=1 and o_addr_r={state_reg, k} for k=0..NUM_ACTIONS-1, one per cycle in ascending order. Both outputs are registered.
- A valid-tag shift register delays the read strobe and action index by 1 cycle to align with i_q_data.
- Compare rules:
  - The first returned value (action 0) unconditionally loads running max/argmax.
  - Each later value replaces them only if strictly greater (signed compare).
  - On ties, the lowest action index wins.
- DONE: the running max/argmax are copied to o_qmax/o_amax in the same cycle as o_done. Both then hold until the next DONE.
- Outside READ: o_read_en=0 and o_addr_r holds its last value.
- The block never writes to the Q-table. Write-port arbitration is external.

## Timing
- Let cycle T be the cycle in which i_start=1 is sampled while o_busy=0.
- Cycles T+1..T+N (N=NUM_ACTIONS): o_read_en=1, action 0..N-1.
- Cycles T+2..T+N+1: i_q_data consumed.
- Cycle T+N+2: o_done=1 with outputs valid. Start-to-done latency is N+2 cycles (6 at defaults).
- o_busy=1 in cycles T+1..T+N+1.
- Back-to-back: i_start in the DONE cycle makes the next read begin in the following cycle. Sustained throughput is one search per N+2 cycles.
- Reset (any state, including mid-search), effective the cycle after i_rst is sampled high:
  - FSM goes to IDLE.
  - o_busy=0, o_done=0, o_read_en=0.
  - o_addr_r=0, o_qmax=0, o_amax=0.
  - Running max and delay tags are cleared.
  - An aborted search produces no o_done. Q-table data returning after reset is discarded.
- i_start held high while i_rst=1 is ignored.

## Test plan
- Basic search:
  - Stimulus: Q-table model holds state 5 = {10, 40, -3, 25}; pulse i_start with i_state=5.
  - Required: reads at addresses 20, 21, 22, 23 on consecutive cycles; o_done exactly 6 cycles after start; o_qmax=40, o_amax=1.
- All-negative values:
  - Stimulus: state 0 = {-7, -2, -9, -2}.
  - Required: o_qmax=-2, o_amax=1 (signed compare; on the tie the lower index wins).
- Extremes:
  - Stimulus: state 2**17-1 = {0x80000000, 0x7FFFFFFF, 0, 0}.
  - Required: addresses 0x7FFFC..0x7FFFF; o_qmax=0x7FFFFFFF, o_amax=1.
- Back-to-back with ignored start:
  - Stimulus: pulse i_start again while o_busy=1, then again in the DONE cycle with a different state.
  - Required: the mid-search start is ignored; the DONE-cycle start triggers reads in the next cycle; two o_done pulses 6 cycles apart, each with correct results.
- Reset mid-search:
  - Stimulus: assert i_rst in cycle T+3.
  - Required: from T+4 all outputs are 0 and no o_done appears. A new search afterwards returns correct results unaffected by stale data.
- Input stability:
  - Stimulus: change i_state every cycle during a search.
  - Required: all four addresses use the state latched at start.
